// File: rtl/data_mem_mmio.sv
// -----------------------------------------------------------------------------
// data_mem_mmio
//
// Data-side memory for the pipelined MIPS core, placed directly after the MEM
// stage. It provides a word-addressed RAM plus three memory-mapped registers:
//   0xFFFF_0000  CNT   free-running cycle counter (writable)
//   0xFFFF_0004  FIFO  write pushes a word; read returns the head without popping
//   0xFFFF_0008  STAT  {count[15:8], overflow[2], empty[1], full[0]}
//                      writing bit2=1 clears the sticky overflow flag
// The FIFO is drained by an external consumer over a valid/ready port.
//
// Ports:
//   clk         rising-edge clock
//   reset       asynchronous, active-high reset (control state only; RAM kept)
//   load        read request from the MEM stage
//   store       write request from the MEM stage
//   address     byte address; bits[1:0] are ignored
//   store_data  write data
//   load_data   combinational read data (0 when load=0 or unmapped)
//   out_data    FIFO head word (0 when empty)
//   out_valid   FIFO non-empty
//   out_ready   consumer accepts the head word this cycle
// -----------------------------------------------------------------------------
module data_mem_mmio #(
    parameter int DEPTH_WORDS = 256,
    parameter int FIFO_DEPTH  = 8
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        load,
    input  logic        store,
    input  logic [31:0] address,
    input  logic [31:0] store_data,
    output logic [31:0] load_data,
    output logic [31:0] out_data,
    output logic        out_valid,
    input  logic        out_ready
);

    localparam int AW = $clog2(DEPTH_WORDS);
    localparam int PW = $clog2(FIFO_DEPTH);

    // Word addresses (byte address >> 2) of the memory-mapped registers.
    localparam logic [29:0] CNT_WADDR  = 30'h3FFF_C000;
    localparam logic [29:0] FIFO_WADDR = 30'h3FFF_C001;
    localparam logic [29:0] STAT_WADDR = 30'h3FFF_C002;

    localparam logic [PW:0] FIFO_FULL_COUNT = (PW+1)'(FIFO_DEPTH);

    // ------------------------------------------------------------------
    // Storage and state
    // ------------------------------------------------------------------
    logic [31:0]   ram      [DEPTH_WORDS];
    logic [31:0]   fifo_mem [FIFO_DEPTH];

    logic [PW-1:0] rd_ptr;
    logic [PW-1:0] wr_ptr;
    logic [PW:0]   fifo_count;
    logic          overflow;
    logic [31:0]   cycle_cnt;

    // ------------------------------------------------------------------
    // Address decode
    // ------------------------------------------------------------------
    logic [29:0]   word_addr;
    logic [AW-1:0] ram_idx;
    logic          sel_ram;
    logic          sel_cnt;
    logic          sel_fifo;
    logic          sel_stat;

    // Byte-lane bits carry no meaning for a word-only memory.
    logic          unused_addr_bits;

    assign word_addr        = address[31:2];
    assign ram_idx          = word_addr[AW-1:0];
    assign unused_addr_bits = ^address[1:0];

    // RAM occupies 0 .. DEPTH_WORDS*4-1: all word-address bits above the
    // index must be zero, so aliases of the RAM are treated as unmapped.
    assign sel_ram  = (word_addr[29:AW] == '0);
    assign sel_cnt  = (word_addr == CNT_WADDR);
    assign sel_fifo = (word_addr == FIFO_WADDR);
    assign sel_stat = (word_addr == STAT_WADDR);

    // ------------------------------------------------------------------
    // FIFO control
    // ------------------------------------------------------------------
    logic        fifo_full;
    logic        fifo_empty;
    logic        pop;
    logic        push_req;
    logic        push_ok;
    logic        ovf_set;
    logic        ovf_clr;
    logic [31:0] status;

    assign fifo_full  = (fifo_count == FIFO_FULL_COUNT);
    assign fifo_empty = (fifo_count == '0);

    assign out_valid  = !fifo_empty;
    // No bypass path: the head comes only from stored entries, and an empty
    // FIFO presents zero instead of stale buffer contents.
    assign out_data   = fifo_empty ? 32'h0 : fifo_mem[rd_ptr];

    assign pop        = out_valid & out_ready;
    assign push_req   = store & sel_fifo;
    // A full FIFO still accepts a push when the head leaves in the same cycle.
    assign push_ok    = push_req & (!fifo_full | pop);
    assign ovf_set    = push_req & fifo_full & !pop;
    assign ovf_clr    = store & sel_stat & store_data[2];

    assign status     = {16'h0, 8'(fifo_count), 5'h0, overflow, fifo_empty, fifo_full};

    // ------------------------------------------------------------------
    // Combinational read mux
    // ------------------------------------------------------------------
    always_comb begin
        load_data = 32'h0;
        if (load) begin
            if (sel_ram) begin
                load_data = ram[ram_idx];
            end else if (sel_cnt) begin
                load_data = cycle_cnt;
            end else if (sel_fifo) begin
                load_data = out_data;
            end else if (sel_stat) begin
                load_data = status;
            end
        end
    end

    // ------------------------------------------------------------------
    // Control state: counter, FIFO pointers/count, overflow flag
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cycle_cnt  <= 32'h0;
            rd_ptr     <= '0;
            wr_ptr     <= '0;
            fifo_count <= '0;
            overflow   <= 1'b0;
        end else begin
            // A CNT write replaces the increment for that cycle.
            if (store && sel_cnt) begin
                cycle_cnt <= store_data;
            end else begin
                cycle_cnt <= cycle_cnt + 32'd1;
            end

            if (pop) begin
                rd_ptr <= rd_ptr + PW'(1);
            end
            if (push_ok) begin
                wr_ptr <= wr_ptr + PW'(1);
            end

            case ({push_ok, pop})
                2'b10:   fifo_count <= fifo_count + (PW+1)'(1);
                2'b01:   fifo_count <= fifo_count - (PW+1)'(1);
                default: fifo_count <= fifo_count;
            endcase

            // Set and clear target different addresses, so they never
            // coincide in one cycle.
            if (ovf_set) begin
                overflow <= 1'b1;
            end else if (ovf_clr) begin
                overflow <= 1'b0;
            end
        end
    end

    // ------------------------------------------------------------------
    // Data storage: RAM and FIFO buffer are not reset
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (store && sel_ram) begin
            ram[ram_idx] <= store_data;
        end
        if (push_ok) begin
            fifo_mem[wr_ptr] <= store_data;
        end
    end

endmodule

// File: tb/tb_data_mem_mmio.sv
// -----------------------------------------------------------------------------
// tb_data_mem_mmio
//
// Self-checking bench for data_mem_mmio. RAM/decode behaviour is driven from a
// table of {inputs, expected load_data} records; counter, FIFO and reset corner
// cases are hand-written sequences. A queue scoreboard holds the words expected
// from the FIFO: words are pushed when a FIFO store is driven and popped and
// compared against out_data when the consumer handshake completes.
// -----------------------------------------------------------------------------
module tb_data_mem_mmio;

    localparam int FD = 8;
    localparam logic [31:0] CNT_A  = 32'hFFFF_0000;
    localparam logic [31:0] FIFO_A = 32'hFFFF_0004;
    localparam logic [31:0] STAT_A = 32'hFFFF_0008;

    logic        clk;
    logic        reset;
    logic        load;
    logic        store;
    logic [31:0] address;
    logic [31:0] store_data;
    logic [31:0] load_data;
    logic [31:0] out_data;
    logic        out_valid;
    logic        out_ready;

    int errors = 0;
    int checks = 0;

    logic [31:0] sb_q[$];

    typedef struct {
        logic        ld;
        logic        st;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic        chk;
        logic [31:0] exp;
    } vec_t;

    vec_t tbl[10];

    data_mem_mmio #(
        .DEPTH_WORDS(256),
        .FIFO_DEPTH (FD)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .load      (load),
        .store     (store),
        .address   (address),
        .store_data(store_data),
        .load_data (load_data),
        .out_data  (out_data),
        .out_valid (out_valid),
        .out_ready (out_ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // One clock cycle: drive at the falling edge, check in the low phase,
    // update the scoreboard, then advance through the rising edge.
    task automatic cycle(input logic ld, input logic st, input logic [31:0] a,
                         input logic [31:0] d, input logic rdy,
                         input logic chk, input logic [31:0] exp, input string nm);
        logic popping;
        logic full;
        load       = ld;
        store      = st;
        address    = a;
        store_data = d;
        out_ready  = rdy;
        #1;
        check("out_valid", {31'h0, out_valid}, {31'h0, sb_q.size() != 0});
        check("out_data", out_data, (sb_q.size() != 0) ? sb_q[0] : 32'h0);
        if (chk) check(nm, load_data, exp);
        popping = (sb_q.size() != 0) && rdy;
        full    = (sb_q.size() == FD);
        if (popping) void'(sb_q.pop_front());
        if (st && a == FIFO_A && (!full || popping)) sb_q.push_back(d);
        @(posedge clk);
        @(negedge clk);
    endtask

    initial begin
        tbl[0] = '{1'b0, 1'b1, 32'h0000_0010, 32'hDEAD_BEEF, 1'b0, 32'h0};
        tbl[1] = '{1'b1, 1'b0, 32'h0000_0013, 32'h0,         1'b1, 32'hDEAD_BEEF};
        tbl[2] = '{1'b1, 1'b0, 32'h0000_2000, 32'h0,         1'b1, 32'h0};
        tbl[3] = '{1'b0, 1'b0, 32'h0000_0010, 32'h0,         1'b1, 32'h0};
        tbl[4] = '{1'b0, 1'b1, 32'h0000_03FC, 32'h1234_5678, 1'b0, 32'h0};
        tbl[5] = '{1'b1, 1'b0, 32'h0000_03FC, 32'h0,         1'b1, 32'h1234_5678};
        tbl[6] = '{1'b1, 1'b0, 32'h0000_0400, 32'h0,         1'b1, 32'h0};
        tbl[7] = '{1'b1, 1'b0, 32'hFFFF_000C, 32'h0,         1'b1, 32'h0};
        tbl[8] = '{1'b1, 1'b1, 32'h0000_0010, 32'hCAFE_F00D, 1'b1, 32'hDEAD_BEEF};
        tbl[9] = '{1'b1, 1'b0, 32'h0000_0010, 32'h0,         1'b1, 32'hCAFE_F00D};

        reset      = 1'b1;
        load       = 1'b0;
        store      = 1'b0;
        address    = 32'h0;
        store_data = 32'h0;
        out_ready  = 1'b0;

        // Reset state
        @(negedge clk);
        load    = 1'b1;
        address = CNT_A;
        #1;
        check("rst_cnt", load_data, 32'h0);
        check("rst_valid", {31'h0, out_valid}, 32'h0);
        check("rst_out_data", out_data, 32'h0);
        address = STAT_A;
        #1;
        check("rst_stat", load_data, 32'h0000_0002);
        load  = 1'b0;
        reset = 1'b0;
        @(posedge clk);
        @(negedge clk);

        // Counter: counts edges since deassert, then load and wrap
        cycle(1'b1, 1'b0, CNT_A, 32'h0, 1'b0, 1'b1, 32'd1, "cnt_1");
        cycle(1'b1, 1'b0, CNT_A, 32'h0, 1'b0, 1'b1, 32'd2, "cnt_2");
        cycle(1'b1, 1'b0, CNT_A, 32'h0, 1'b0, 1'b1, 32'd3, "cnt_3");
        cycle(1'b0, 1'b1, CNT_A, 32'hFFFF_FFFE, 1'b0, 1'b0, 32'h0, "cnt_wr");
        cycle(1'b1, 1'b0, CNT_A, 32'h0, 1'b0, 1'b1, 32'hFFFF_FFFE, "cnt_ld");
        cycle(1'b1, 1'b0, CNT_A, 32'h0, 1'b0, 1'b1, 32'hFFFF_FFFF, "cnt_max");
        cycle(1'b1, 1'b0, CNT_A, 32'h0, 1'b0, 1'b1, 32'h0, "cnt_wrap");

        // RAM and decode table
        for (int i = 0; i < 10; i++) begin
            cycle(tbl[i].ld, tbl[i].st, tbl[i].addr, tbl[i].wdata, 1'b0,
                  tbl[i].chk, tbl[i].exp, $sformatf("tbl%0d", i));
        end

        // Fill past full with no consumer: 9th word lost, overflow set
        for (int i = 1; i <= 9; i++) begin
            cycle(1'b0, 1'b1, FIFO_A, 32'(i), 1'b0, 1'b0, 32'h0, "push");
        end
        cycle(1'b1, 1'b0, STAT_A, 32'h0, 1'b0, 1'b1, 32'h0000_0805, "stat_full");
        cycle(1'b1, 1'b0, FIFO_A, 32'h0, 1'b0, 1'b1, 32'h0000_0001, "fifo_rd_head");

        // Push while full with a same-cycle pop
        cycle(1'b0, 1'b1, FIFO_A, 32'h0000_000A, 1'b1, 1'b0, 32'h0, "push_pop_full");
        cycle(1'b1, 1'b0, STAT_A, 32'h0, 1'b0, 1'b1, 32'h0000_0805, "stat_still_full");
        for (int i = 0; i < 8; i++) begin
            cycle(1'b0, 1'b0, 32'h0, 32'h0, 1'b1, 1'b0, 32'h0, "drain");
        end
        cycle(1'b0, 1'b0, 32'h0, 32'h0, 1'b1, 1'b0, 32'h0, "ready_empty");
        cycle(1'b1, 1'b0, STAT_A, 32'h0, 1'b0, 1'b1, 32'h0000_0006, "stat_ovf");
        cycle(1'b1, 1'b0, FIFO_A, 32'h0, 1'b0, 1'b1, 32'h0, "fifo_rd_empty");
        cycle(1'b0, 1'b1, STAT_A, 32'h0000_0003, 1'b0, 1'b0, 32'h0, "stat_wr_noclr");
        cycle(1'b1, 1'b0, STAT_A, 32'h0, 1'b0, 1'b1, 32'h0000_0006, "stat_ovf_kept");
        cycle(1'b0, 1'b1, STAT_A, 32'h0000_0004, 1'b0, 1'b0, 32'h0, "stat_clr");
        cycle(1'b1, 1'b0, STAT_A, 32'h0, 1'b0, 1'b1, 32'h0000_0002, "stat_cleared");

        // Push into empty: visible one edge later, then popped
        cycle(1'b0, 1'b1, FIFO_A, 32'h0000_0055, 1'b0, 1'b0, 32'h0, "push_55");
        cycle(1'b0, 1'b0, 32'h0, 32'h0, 1'b1, 1'b0, 32'h0, "pop_55");
        cycle(1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 32'h0, "empty_after_55");

        // Push and pop together on a partly filled FIFO keep the count
        cycle(1'b0, 1'b1, FIFO_A, 32'h0000_0011, 1'b0, 1'b0, 32'h0, "push_11");
        cycle(1'b0, 1'b1, FIFO_A, 32'h0000_0022, 1'b0, 1'b0, 32'h0, "push_22");
        cycle(1'b1, 1'b0, STAT_A, 32'h0, 1'b0, 1'b1, 32'h0000_0200, "stat_cnt2");
        cycle(1'b0, 1'b1, FIFO_A, 32'h0000_0033, 1'b1, 1'b0, 32'h0, "push_pop");
        cycle(1'b1, 1'b0, STAT_A, 32'h0, 1'b0, 1'b1, 32'h0000_0200, "stat_cnt2_kept");

        // Reset mid-operation with one more word queued
        cycle(1'b0, 1'b1, FIFO_A, 32'h0000_0044, 1'b0, 1'b0, 32'h0, "push_44");
        store   = 1'b0;
        load    = 1'b1;
        address = STAT_A;
        reset   = 1'b1;
        #1;
        check("mid_rst_valid", {31'h0, out_valid}, 32'h0);
        check("mid_rst_out_data", out_data, 32'h0);
        check("mid_rst_stat", load_data, 32'h0000_0002);
        address = 32'h0000_03FC;
        #1;
        check("mid_rst_ram", load_data, 32'h1234_5678);
        address = CNT_A;
        #1;
        check("mid_rst_cnt", load_data, 32'h0);
        sb_q.delete();
        @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        load  = 1'b0;
        @(posedge clk);
        @(negedge clk);
        cycle(1'b1, 1'b0, CNT_A, 32'h0, 1'b1, 1'b1, 32'd1, "cnt_after_rst");
        cycle(1'b1, 1'b0, 32'h0000_0010, 32'h0, 1'b0, 1'b1, 32'hCAFE_F00D, "ram_after_rst");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
